// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline merge/branch blocks.
// Holds the merge source tag encoding and the starvation counter width.
package pipeline_pkg;

  typedef enum logic {
    SRC_MAIN = 1'b0,
    SRC_SCND = 1'b1
  } merge_src_e;

  function automatic int cnt_width(input int max_starve);
    return (max_starve < 1) ? 1 : $clog2(max_starve + 1);
  endfunction

endpackage

// File: rtl/pipeline_merge_arb.sv
// Fixed-priority main/secondary arbiter with a bounded-starvation guard.
// Secondary is forced through after MaxStarve back-to-back main wins.
module pipeline_merge_arb
  import pipeline_pkg::*;
#(
  parameter int MaxStarve = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic main_valid,
  input  logic scnd_valid,
  input  logic space,
  input  logic main_hs,
  input  logic scnd_hs,
  output logic grant_main,
  output logic grant_scnd
);

  localparam int W = cnt_width(MaxStarve);
  localparam logic [W-1:0] MaxCnt = W'(MaxStarve);

  logic [W-1:0] starve_cnt;
  logic         force_scnd;

  assign force_scnd = (MaxStarve != 0) && (starve_cnt == MaxCnt)
                      && scnd_valid;
  assign grant_main = space & main_valid & ~force_scnd;
  assign grant_scnd = space & scnd_valid & ~grant_main;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (main_hs && scnd_valid) begin
      if (starve_cnt != MaxCnt) starve_cnt <= starve_cnt + 1'b1;
    end else if (scnd_hs || !scnd_valid) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/pipeline_merge.sv
// Two-input elastic merge with a registered 2-entry skid buffer output.
// Define PIPELINE_MERGE_SOURCE_TAG_EN to add the data_out_src_o tag port.
module pipeline_merge
  import pipeline_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int MaxStarve = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [DataWidth-1:0] data_in_main_i,
  input  logic                 data_in_main_valid_i,
  output logic                 data_in_main_ready_o,
  input  logic [DataWidth-1:0] data_in_scnd_i,
  input  logic                 data_in_scnd_valid_i,
  output logic                 data_in_scnd_ready_o,
  output logic [DataWidth-1:0] data_out_o,
  output logic                 data_out_valid_o,
`ifdef PIPELINE_MERGE_SOURCE_TAG_EN
  output logic                 data_out_src_o,
`endif
  input  logic                 data_out_ready_i
);

  logic [1:0]           count;
  logic [DataWidth-1:0] buf_data [2];
  logic [DataWidth-1:0] push_data;
  logic space, pop, push;
  logic main_hs, scnd_hs;
  logic grant_main, grant_scnd;
  logic wr_head, wr_tail, shift;

  pipeline_merge_arb #(
    .MaxStarve (MaxStarve)
  ) u_arb (
    .clk        (clk_i),
    .rst        (arst_i),
    .main_valid (data_in_main_valid_i),
    .scnd_valid (data_in_scnd_valid_i),
    .space      (space),
    .main_hs    (main_hs),
    .scnd_hs    (scnd_hs),
    .grant_main (grant_main),
    .grant_scnd (grant_scnd)
  );

  assign space            = count != 2'd2;
  assign data_out_valid_o = count != 2'd0;
  assign data_out_o       = buf_data[0];
  assign pop              = data_out_valid_o & data_out_ready_i;

  assign data_in_main_ready_o = ~arst_i & grant_main;
  assign data_in_scnd_ready_o = ~arst_i & grant_scnd;

  assign main_hs   = data_in_main_valid_i & data_in_main_ready_o;
  assign scnd_hs   = data_in_scnd_valid_i & data_in_scnd_ready_o;
  assign push      = main_hs | scnd_hs;
  assign push_data = main_hs ? data_in_main_i : data_in_scnd_i;

  // Head is only rewritten on demand so an empty buffer keeps its last beat.
  assign wr_head = push & ((count == 2'd0) | ((count == 2'd1) & pop));
  assign wr_tail = push & (count == 2'd1) & ~pop;
  assign shift   = pop & (count == 2'd2);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      count       <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (wr_head)    buf_data[0] <= push_data;
      else if (shift) buf_data[0] <= buf_data[1];
      if (wr_tail)    buf_data[1] <= push_data;
    end
  end

`ifdef PIPELINE_MERGE_SOURCE_TAG_EN
  merge_src_e buf_src [2];
  merge_src_e push_src;

  assign push_src       = main_hs ? SRC_MAIN : SRC_SCND;
  assign data_out_src_o = buf_src[0];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      buf_src[0] <= SRC_MAIN;
      buf_src[1] <= SRC_MAIN;
    end else begin
      if (wr_head)    buf_src[0] <= push_src;
      else if (shift) buf_src[0] <= buf_src[1];
      if (wr_tail)    buf_src[1] <= push_src;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_merge.sv
// Scoreboard bench for pipeline_merge (MaxStarve 4 and 0 instances).
// Expected beats are queued as {src,data}; monitors pop on each output beat.
module tb_pipeline_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst;
  logic [7:0] m_data, s_data, o_data;
  logic m_valid, m_ready, s_valid, s_ready, o_valid, o_ready;
  logic [7:0] z_m_data, z_s_data, z_o_data;
  logic z_m_valid, z_m_ready, z_s_valid, z_s_ready, z_o_valid, z_o_ready;
`ifdef PIPELINE_MERGE_SOURCE_TAG_EN
  logic o_src, z_src;
`endif

  pipeline_merge #(.DataWidth(8), .MaxStarve(4)) dut (
    .clk_i                (clk),
    .arst_i               (arst),
    .data_in_main_i       (m_data),
    .data_in_main_valid_i (m_valid),
    .data_in_main_ready_o (m_ready),
    .data_in_scnd_i       (s_data),
    .data_in_scnd_valid_i (s_valid),
    .data_in_scnd_ready_o (s_ready),
    .data_out_o           (o_data),
    .data_out_valid_o     (o_valid),
`ifdef PIPELINE_MERGE_SOURCE_TAG_EN
    .data_out_src_o       (o_src),
`endif
    .data_out_ready_i     (o_ready)
  );

  pipeline_merge #(.DataWidth(8), .MaxStarve(0)) dut0 (
    .clk_i                (clk),
    .arst_i               (arst),
    .data_in_main_i       (z_m_data),
    .data_in_main_valid_i (z_m_valid),
    .data_in_main_ready_o (z_m_ready),
    .data_in_scnd_i       (z_s_data),
    .data_in_scnd_valid_i (z_s_valid),
    .data_in_scnd_ready_o (z_s_ready),
    .data_out_o           (z_o_data),
    .data_out_valid_o     (z_o_valid),
`ifdef PIPELINE_MERGE_SOURCE_TAG_EN
    .data_out_src_o       (z_src),
`endif
    .data_out_ready_i     (z_o_ready)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] q[$];
  logic [8:0] q0[$];

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Called just after a rising edge; returns after the handshake edge + 1.
  task automatic drive(input int chan, input logic [7:0] d, output int tries);
    logic hs;
    tries = 0;
    hs = 1'b0;
    case (chan)
      0: begin m_valid = 1'b1; m_data = d; end
      1: begin s_valid = 1'b1; s_data = d; end
      default: begin z_m_valid = 1'b1; z_m_data = d; end
    endcase
    while (!hs && tries < 50) begin
      @(negedge clk);
      hs = (chan == 0) ? m_ready : (chan == 1) ? s_ready : z_m_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!hs) fail_timeout("drive_hs");
    case (chan)
      0: m_valid = 1'b0;
      1: s_valid = 1'b0;
      default: z_m_valid = 1'b0;
    endcase
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0 || q0.size() != 0) fail_timeout("drain");
  endtask

  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (!arst && o_valid && o_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_extra: got %0h expected none", o_data);
      end else begin
        e = q.pop_front();
        check("out_data", {1'b0, o_data}, {1'b0, e[7:0]});
`ifdef PIPELINE_MERGE_SOURCE_TAG_EN
        check("out_src", {8'h0, o_src}, {8'h0, e[8]});
`endif
      end
    end
  end

  always @(negedge clk) begin : mon0
    logic [8:0] e;
    if (!arst && z_o_valid && z_o_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out0_extra: got %0h expected none", z_o_data);
      end else begin
        e = q0.pop_front();
        check("out0_data", {1'b0, z_o_data}, {1'b0, e[7:0]});
`ifdef PIPELINE_MERGE_SOURCE_TAG_EN
        check("out0_src", {8'h0, z_src}, {8'h0, e[8]});
`endif
      end
    end
    if (!arst && z_s_valid) check("z_scnd_ready", {8'h0, z_s_ready}, 9'h0);
  end

  initial begin
    int t;
    int mi, si;
    m_valid = 0; s_valid = 0; m_data = 0; s_data = 0; o_ready = 0;
    z_m_valid = 0; z_s_valid = 0; z_m_data = 0; z_s_data = 0;
    z_o_ready = 1;
    arst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 1; s_valid = 1;
    #1;
    check("rst_main_ready", {8'h0, m_ready}, 9'h0);
    check("rst_scnd_ready", {8'h0, s_ready}, 9'h0);
    check("rst_valid", {8'h0, o_valid}, 9'h0);
    check("rst_data", {1'b0, o_data}, 9'h0);
    m_valid = 0; s_valid = 0;
    @(negedge clk) arst = 0;
    @(posedge clk);
    #1;

    // Backpressure: fill, then pop while full must not admit a push.
    o_ready = 0;
    q.push_back({1'b0, 8'hA1});
    drive(0, 8'hA1, t);
    q.push_back({1'b0, 8'hA2});
    drive(0, 8'hA2, t);
    m_valid = 1; m_data = 8'hA3; s_valid = 1; s_data = 8'hB3;
    @(negedge clk);
    check("full_main_ready", {8'h0, m_ready}, 9'h0);
    check("full_scnd_ready", {8'h0, s_ready}, 9'h0);
    check("full_valid", {8'h0, o_valid}, 9'h1);
    check("full_head", {1'b0, o_data}, {1'b0, 8'hA1});
    @(posedge clk);
    #1;
    s_valid = 0; o_ready = 1;
    q.push_back({1'b0, 8'hA3});
    @(negedge clk);
    check("full_pop_no_push", {8'h0, m_ready}, 9'h0);
    @(negedge clk);
    check("after_pop_ready", {8'h0, m_ready}, 9'h1);
    @(posedge clk);
    #1;
    m_valid = 0;
    wait_drain();

    // Secondary-only streaming at full rate.
    for (int i = 0; i < 16; i++) begin
      q.push_back({1'b1, 8'(i)});
      drive(1, 8'(i), t);
      check("tput_tries", 9'(t), 9'd1);
      check("tput_out", {o_valid, o_data}, {1'b1, 8'(i)});
    end
    wait_drain();

    q.push_back({1'b0, 8'h55});
    drive(0, 8'h55, t);
    q.push_back({1'b1, 8'hAA});
    drive(1, 8'hAA, t);
    wait_drain();

    // Contention: expect M,M,M,M,S repeating.
    mi = 0; si = 0;
    for (int k = 0; k < 15; k++) begin
      if (k % 5 == 4) begin
        q.push_back({1'b1, 8'(8'h80 + si)});
        si++;
      end else begin
        q.push_back({1'b0, 8'(8'h40 + mi)});
        mi++;
      end
    end
    fork
      begin
        int tm;
        for (int i = 0; i < 12; i++) drive(0, 8'(8'h40 + i), tm);
      end
      begin
        int ts;
        for (int i = 0; i < 3; i++) drive(1, 8'(8'h80 + i), ts);
      end
    join
    wait_drain();

    // MaxStarve = 0: secondary never wins while main is valid.
    z_s_valid = 1; z_s_data = 8'h99;
    for (int i = 0; i < 20; i++) begin
      q0.push_back({1'b0, 8'(8'h20 + i)});
      drive(2, 8'(8'h20 + i), t);
    end
    z_s_valid = 0;
    wait_drain();

    // Reset mid-stream discards buffered beats.
    o_ready = 0;
    drive(0, 8'h31, t);
    drive(0, 8'h32, t);
    check("pre_rst_valid", {8'h0, o_valid}, 9'h1);
    m_valid = 1; m_data = 8'h11;
    #2 arst = 1;
    #1;
    check("midrst_valid", {8'h0, o_valid}, 9'h0);
    check("midrst_main_ready", {8'h0, m_ready}, 9'h0);
    check("midrst_scnd_ready", {8'h0, s_ready}, 9'h0);
    check("midrst_data", {1'b0, o_data}, 9'h0);
    o_ready = 1;
    q.push_back({1'b0, 8'h11});
    @(negedge clk) arst = 0;
    @(posedge clk);
    #1;
    m_valid = 0;
    check("post_rst_out", {o_valid, o_data}, {1'b1, 8'h11});
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_merge.md
Name: pipeline_merge

Overview:
- Two-input, one-output elastic merge stage. It is the converging counterpart of the pipeline branch: it recombines a main and a secondary valid/ready stream into a single stream.
- Arbitration is fixed-priority in favour of main, with a bounded-starvation guard for secondary.
- Output is registered through an internal 2-entry skid buffer, so throughput is one beat per cycle and there is no combinational path from output ready to output data or valid.

Parameters:
DataWidth, 8, payload width in bits
MaxStarve, 4, max consecutive main grants while secondary is waiting; 0 = pure fixed priority with guard disabled

Ports:
clk_i  input  1  clock, all state updates on rising edge
arst_i  input  1  asynchronous active-high reset
data_in_main_i  input  DataWidth  main input payload
data_in_main_valid_i  input  1  main input valid
data_in_main_ready_o  output  1  main input ready
data_in_scnd_i  input  DataWidth  secondary input payload
data_in_scnd_valid_i  input  1  secondary input valid
data_in_scnd_ready_o  output  1  secondary input ready
data_out_o  output  DataWidth  merged output payload (registered)
data_out_valid_o  output  1  merged output valid (registered)
data_out_ready_i  input  1  downstream ready

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high. Ports are clk_i and arst_i.
- Reset values while arst_i is high:
  - data_out_o = 0, data_out_valid_o = 0
  - buffer count = 0, starve_cnt = 0
  - both input readies forced to 0
- Buffer:
  - 2-entry FIFO-ordered skid buffer; count ranges 0..2.
  - space = (count != 2).
  - data_out_valid_o = (count != 0); data_out_o = head entry.
  - pop = data_out_valid_o & data_out_ready_i.
- Arbitration (combinational, evaluated only when space = 1):
  - force_scnd = (MaxStarve != 0) & (starve_cnt == MaxStarve) & data_in_scnd_valid_i.
  - grant_main = data_in_main_valid_i & ~force_scnd.
  - grant_scnd = data_in_scnd_valid_i & ~grant_main.
  - data_in_main_ready_o = space & grant_main; data_in_scnd_ready_o = space & grant_scnd.
  - At most one push per cycle. A ready is never asserted toward a channel that is not granted.
- Push: a handshake on either input writes the selected payload into the buffer tail.
- Latency: 1 cycle from input handshake to data_out_valid_o.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: count unchanged; at count 1 the head is replaced by the new beat in order.
- Full (count = 2): both readies are 0. A pop in that cycle does not enable a same-cycle push; readies rise the next cycle.
- Empty: data_out_valid_o = 0 and data_out_o holds its last value.
- Starvation counter (width $clog2(MaxStarve+1), minimum 1):
  - main handshake while scnd valid: increment, saturating at MaxStarve
  - scnd handshake, or scnd valid low: clear to 0
  - otherwise: hold
- Reset asserted mid-operation discards all buffered beats immediately (asynchronously). There is no partial-state recovery.
- Input valid must be held until its handshake. Payload stability is the source's responsibility; the block does not check it.

Optional Feature:
- Macro: PIPELINE_MERGE_SOURCE_TAG_EN.
- When defined:
  - Adds output port data_out_src_o (1 bit): 0 = beat came from main, 1 = beat came from secondary.
  - The tag is stored per buffer entry alongside the payload and has reset value 0.
- When undefined: the port and tag storage are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef merge_src_e (SRC_MAIN = 1'b0, SRC_SCND = 1'b1)
  - localparam-style function for counter width
- Sub-module pipeline_merge_arb holds the grant logic and starvation counter. Inputs: both valids, space, handshake flags. Outputs: grant_main, grant_scnd.
- The skid buffer stays inline in pipeline_merge.

Test Plan:
- Reset mid-stream: 2 beats buffered, assert arst_i -> valid_o = 0, both readies = 0 immediately. Release with only main valid = 0x11 -> out 0x11 one cycle later.
- Contention, MaxStarve = 4, both valid constantly, out ready = 1 -> output sources follow M,M,M,M,S repeating; scnd beat appears as every 5th output.
- MaxStarve = 0, both valid for 20 cycles -> all 20 outputs come from main; data_in_scnd_ready_o stays 0.
- Backpressure: out ready = 0, push 0xA1, 0xA2 -> count = 2, both readies = 0. Raise ready -> 0xA1 then 0xA2 in order, no loss or duplication.
- Full throughput: scnd only, 16 beats 0x00..0x0F, out ready = 1 -> 16 outputs on consecutive cycles, first one cycle after first handshake.
- With PIPELINE_MERGE_SOURCE_TAG_EN: main 0x55 then scnd 0xAA -> data_out_src_o = 0 then 1, aligned with each beat.
